line_follow_pwm_ctrl: RTL

Parametrised two-motor line-follower controller, successor to the fixed 3-bit-duty design. Takes the left/right line sensors and a duty command, and drives two PWM motor outputs through a steering state machine. It adds configurable PWM resolution, synchronised and debounced sensors, lost-line direction memory, and an optional soft-start/soft-stop duty ramp. Sits between the chip pin mux and the motor driver pins.

---
 rtl/line_follow_pwm_ctrl_if.sv | 25 ++
 rtl/line_follow_pwm_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/line_follow_pwm_ctrl_if.sv
// Pin-side bundle of the line-follower controller: run/sensor/duty inputs and
// the PWM, state and phase-counter outputs.
interface line_follow_pwm_ctrl_if #(
  parameter int PWM_W = 3
);
  logic             en;
  logic             l_sens;
  logic             r_sens;
  logic [PWM_W-1:0] duty;
  logic             pwm_l;
  logic             pwm_r;
  logic [1:0]       state;
  logic [PWM_W-1:0] cnt;
  logic             period_end;

  modport master (
    output en, l_sens, r_sens, duty,
    input  pwm_l, pwm_r, state, cnt, period_end
  );

  modport slave (
    input  en, l_sens, r_sens, duty,
    output pwm_l, pwm_r, state, cnt, period_end
  );
endinterface

// File: rtl/line_follow_pwm_ctrl.sv
// Two-motor line-follower: synchronised/debounced sensors feed a steering FSM
// that updates motor duty levels once per PWM period, optionally ramped.
module line_follow_pwm_ctrl #(
  parameter int PWM_W   = 3,
  parameter int DEB_CYC = 4,
  parameter bit RAMP    = 1'b0
) (
  input logic                   clk,
  input logic                   rst_n,
  line_follow_pwm_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FWD    = 2'd1,
    TURN_L = 2'd2,
    TURN_R = 2'd3
  } state_t;

  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic [PWM_W-1:0]     cnt;
  logic                 period_end;
  logic [1:0]           sync1, sync2, deb;   // bit 1 = left, bit 0 = right
  logic [1:0][DW-1:0]   deb_cnt;
  state_t               state_q, state_d;
  logic [PWM_W-1:0]     level_l, level_r;
  logic [PWM_W-1:0]     tgt_l, tgt_r;

  assign period_end = &cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + 1'b1;
  end

  // NOTE: the small per-sensor counter arrays are plain flops, so they are
  // reset along with everything else; nothing here is a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      deb     <= '0;
      deb_cnt <= '0;
    end else begin
      sync1 <= {bus.l_sens, bus.r_sens};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYC - 1)) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (period_end) begin
      if (!bus.en)                state_d = IDLE;
      else if (deb[1] && deb[0])  state_d = FWD;
      else if (deb[1])            state_d = TURN_L;
      else if (deb[0])            state_d = TURN_R;
      else if (state_q == IDLE)   state_d = FWD;
    end
  end

  always_comb begin
    tgt_l = '0;
    tgt_r = '0;
    case (state_d)
      FWD:     begin tgt_l = bus.duty; tgt_r = bus.duty; end
      TURN_L:  tgt_r = bus.duty;
      TURN_R:  tgt_l = bus.duty;
      default: ;
    endcase
  end

  function automatic logic [PWM_W-1:0] next_level(input logic [PWM_W-1:0] cur,
                                                  input logic [PWM_W-1:0] tgt);
    if (!RAMP)     return tgt;
    if (cur < tgt) return cur + 1'b1;
    if (cur > tgt) return cur - 1'b1;
    return cur;
  endfunction

  // Levels only move on the wrap edge, so duty/en changes mid-period are inert.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_l <= '0;
      level_r <= '0;
    end else if (period_end) begin
      level_l <= next_level(level_l, tgt_l);
      level_r <= next_level(level_r, tgt_r);
    end
  end

  assign bus.pwm_l      = (cnt < level_l);
  assign bus.pwm_r      = (cnt < level_r);
  assign bus.state      = state_q;
  assign bus.cnt        = cnt;
  assign bus.period_end = period_end;

endmodule
